quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
//
// PURPOSE
//   Decodes a 2-channel quadrature encoder (A/B) into single-cycle step/direction pulses
//   and an up/down position count. This is the producer side of the up/down counter
//   interface: o_step/o_dir are the increment/decrement command stream, o_position is
//   the running count. Sits between asynchronous encoder pins and any downstream
//   position/velocity logic.
//
// PARAMETERS
//   BITS         8  width of o_position
//   SYNC_STAGES  2  synchronizer flops per channel (>=2)
//   FILTER_LEN   3  consecutive stable cycles before a channel level is accepted (>=1)
//
// PORTS
//   clock       in   1     clock
//   reset       in   1     reset, synchronous, active-high
//   i_a         in   1     encoder channel A, asynchronous
//   i_b         in   1     encoder channel B, asynchronous
//   i_clear     in   1     synchronous clear of o_position
//   o_step      out  1     1-cycle pulse per accepted quadrature transition
//   o_dir       out  1     direction of last step: 1 = increment, 0 = decrement
//   o_position  out  BITS  signed-agnostic up/down position count
//   o_error     out  1     1-cycle pulse: both filtered channels changed in the same cycle
//
// BEHAVIOUR
//   - Reset: all sync/filter flops 0, FSM=INIT, o_step=0, o_dir=0, o_position=0, o_error=0.
//   - Sync: each channel passes through SYNC_STAGES flops; no logic ahead of the first flop.
//   - Filter (per channel): counter clears whenever sync output == filtered level; else
//     increments. Filtered level takes the sync value on the cycle the counter reaches
//     FILTER_LEN. Glitches shorter than FILTER_LEN cycles never reach the filtered level.
//   - FSM INIT: waits until both channels' sync outputs have been stable for FILTER_LEN
//     cycles, then loads {A,B} into the state register with no step/error, -> TRACK.
//     This ensures a non-00 encoder level at reset never produces a spurious step.
//   - FSM TRACK: compares new filtered {A,B} against the stored state each cycle:
//       forward  00->01->11->10->00 : o_step=1, o_dir=1, o_position+1
//       reverse  00->10->11->01->00 : o_step=1, o_dir=0, o_position-1
//       no change                   : o_step=0, o_dir holds
//       both bits changed           : o_error=1, o_step=0, o_position/o_dir hold;
//                                     state register adopts the new value
//   - Latency: a clean level change on one pin, first sampled at edge k, gives o_step=1
//     in the cycle after edge k+SYNC_STAGES+FILTER_LEN. All outputs are registered.
//   - Arithmetic: o_position is modulo 2^BITS. 2^BITS-1 forward -> 0; 0 reverse -> 2^BITS-1.
//   - i_clear: o_position=0 next cycle. It wins over a same-cycle step, but
//     o_step/o_dir still pulse. FSM and filter state are unaffected.
//   - reset mid-operation: everything returns to its reset values next cycle and the FSM
//     re-enters INIT, whatever the pin levels.
//   - Max trackable rate: one transition per FILTER_LEN+1 cycles; faster input is out of
//     spec and shows up as o_error or missed steps.
//
// TESTING
//   1. Reset, pins 00; 4 forward transitions 8 cycles apart -> 4 o_step pulses, o_dir=1,
//      o_position=4, o_error never 1.
//   2. From 4: 6 reverse transitions -> o_position=254 (BITS=8), o_dir=0 on each step.
//   3. Reset with pins held at 11 -> INIT loads 11, no o_step, o_position=0; then 11->10
//      -> o_position=1.
//   4. 2-cycle glitch on A (FILTER_LEN=3) -> no o_step, no o_error, o_position unchanged.
//   5. A and B toggled in the same cycle 00->11 -> exactly one o_error pulse,
//      o_position unchanged; next 11->10 -> o_position+1.
//   6. i_clear asserted in the same cycle as a step (from 10) -> o_step=1, o_position=0;
//      reset asserted mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/quadrature_decoder_if.sv
// Encoder pin / step-command bundle between quadrature pins, decoder and its consumer.
interface quadrature_decoder_if #(
    parameter int unsigned BITS = 8
);
    logic            i_a;
    logic            i_b;
    logic            i_clear;
    logic            o_step;
    logic            o_dir;
    logic [BITS-1:0] o_position;
    logic            o_error;

    // Pin/consumer side: drives the encoder pins and clear, observes the decoded stream.
    modport master (
        output i_a, i_b, i_clear,
        input  o_step, o_dir, o_position, o_error
    );

    // Decoder side.
    modport slave (
        input  i_a, i_b, i_clear,
        output o_step, o_dir, o_position, o_error
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronizer, per-channel glitch filter, INIT/TRACK FSM
// producing single-cycle step/direction pulses and a modulo-2^BITS position count.
module quadrature_decoder #(
    parameter int unsigned BITS        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    quadrature_decoder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned LAST  = SYNC_STAGES - 1;

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    logic [SYNC_STAGES-1:0]  sync_a_q, sync_b_q;
    logic [1:0]              sync_lvl;
    logic [1:0]              filt_q, filt_d;
    logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
    state_t                  state_q, state_d;
    logic [1:0]              ab_q, ab_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic [BITS-1:0]         pos_q, pos_d;

    // Bit 1 = channel A, bit 0 = channel B throughout.
    assign sync_lvl = {sync_a_q[LAST], sync_b_q[LAST]};

    // Filter: level is accepted once the sync output disagrees for FILTER_LEN cycles.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync_lvl[ch] == filt_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_W'(FILTER_LEN - 1)) begin
                filt_d[ch] = sync_lvl[ch];
                cnt_d[ch]  = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // FSM next-state and registered outputs.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ab_d       = ab_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        dir_d      = dir_q;
        pos_d      = pos_q;
        unique case (state_q)
            ST_INIT: begin
                // Wait for both channels settled, so a non-00 start level is adopted silently.
                if (sync_lvl != filt_q) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    init_cnt_d = '0;
                    ab_d       = filt_q;
                    state_d    = ST_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            ST_TRACK: begin
                ab_d = filt_q;
                case ({ab_q, filt_q})
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + BITS'(1);
                    end
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - BITS'(1);
                    end
                    4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                        err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
        if (bus.i_clear) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            filt_q     <= '0;
            cnt_q      <= '0;
            init_cnt_q <= '0;
            state_q    <= ST_INIT;
            ab_q       <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            sync_a_q   <= {sync_a_q[SYNC_STAGES-2:0], bus.i_a};
            sync_b_q   <= {sync_b_q[SYNC_STAGES-2:0], bus.i_b};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            init_cnt_q <= init_cnt_d;
            state_q    <= state_d;
            ab_q       <= ab_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    assign bus.o_step     = step_q;
    assign bus.o_dir      = dir_q;
    assign bus.o_error    = err_q;
    assign bus.o_position = pos_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: behavioural pin-history model checked every cycle,
// directed scenarios with literal expectations, then randomized encoder activity.
module tb_quadrature_decoder;
    localparam int unsigned BITS = 8;
    localparam int unsigned S    = 2;
    localparam int unsigned F    = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int step_cnt = 0;
    int err_cnt  = 0;

    quadrature_decoder_if #(.BITS(BITS)) bus ();

    quadrature_decoder #(.BITS(BITS), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Model state: pin samples, sync history, accepted levels, decoded outputs.
    logic [1:0]      pin_hist[$];
    logic [1:0]      sync_hist[$];
    logic [1:0]      m_filt = 2'b00;
    int              settle_run = 0;
    bit              m_track = 1'b0;
    logic [1:0]      m_ab = 2'b00;
    logic            m_step = 1'b0, m_dir = 1'b0, m_err = 1'b0;
    logic [BITS-1:0] m_pos = '0;
    logic [1:0]      gray_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int gray_idx(logic [1:0] v);
        for (int i = 0; i < 4; i++) if (gray_seq[i] == v) return i;
        return 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin : model
        logic [1:0] s_pre, f_old, f_new;
        bit all_diff;
        int d;
        if (reset) begin
            pin_hist.delete();
            sync_hist.delete();
            m_filt = 2'b00; settle_run = 0; m_track = 1'b0; m_ab = 2'b00;
            m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_pos = '0;
        end else begin
            // Sync output seen at this edge is the pin level sampled S edges earlier.
            s_pre = (pin_hist.size() >= S) ? pin_hist[S-1] : 2'b00;
            pin_hist.push_front({bus.i_a, bus.i_b});
            if (pin_hist.size() > S + 1) void'(pin_hist.pop_back());
            sync_hist.push_front(s_pre);
            if (sync_hist.size() > F) void'(sync_hist.pop_back());
            f_old = m_filt;
            f_new = f_old;
            for (int ch = 0; ch < 2; ch++) begin
                all_diff = 1'b1;
                for (int i = 0; i < F; i++)
                    if (i >= sync_hist.size() || sync_hist[i][ch] == f_old[ch]) all_diff = 1'b0;
                if (all_diff) f_new[ch] = ~f_old[ch];
            end
            m_step = 1'b0;
            m_err  = 1'b0;
            if (!m_track) begin
                settle_run = (s_pre == f_old) ? settle_run + 1 : 0;
                if (settle_run >= F) begin
                    m_track = 1'b1;
                    m_ab    = f_old;
                end
            end else begin
                d = (gray_idx(f_old) - gray_idx(m_ab) + 4) % 4;
                if (d == 1) begin m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 1'b1; end
                else if (d == 3) begin m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 1'b1; end
                else if (d == 2) m_err = 1'b1;
                m_ab = f_old;
            end
            if (bus.i_clear) m_pos = '0;
            m_filt = f_new;
        end
    end

    always @(negedge clock) begin : compare
        check("step", 32'(bus.o_step), 32'(m_step));
        check("dir", 32'(bus.o_dir), 32'(m_dir));
        check("error", 32'(bus.o_error), 32'(m_err));
        check("position", 32'(bus.o_position), 32'(m_pos));
        if (bus.o_step === 1'b1) step_cnt++;
        if (bus.o_error === 1'b1) err_cnt++;
    end

    logic [1:0] cur = 2'b00;

    task automatic drive(logic [1:0] v);
        @(negedge clock);
        bus.i_a = v[1];
        bus.i_b = v[0];
        cur = v;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset(logic [1:0] pins);
        @(negedge clock);
        reset = 1'b1;
        bus.i_a = pins[1];
        bus.i_b = pins[0];
        cur = pins;
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] next_code(logic [1:0] v, bit fwd);
        return gray_seq[(gray_idx(v) + (fwd ? 1 : 3)) % 4];
    endfunction

    initial begin
        int s0, e0;
        bus.i_a = 1'b0; bus.i_b = 1'b0; bus.i_clear = 1'b0;
        @(negedge clock);
        check("reset_pos", 32'(bus.o_position), 32'd0);
        check("reset_step", 32'(bus.o_step), 32'd0);

        // 1: four forward transitions
        do_reset(2'b00); idle(12);
        s0 = step_cnt; e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin drive(next_code(cur, 1'b1)); idle(7); end
        idle(8);
        check("t1_pos", 32'(bus.o_position), 32'd4);
        check("t1_dir", 32'(bus.o_dir), 32'd1);
        check("t1_steps", 32'(step_cnt - s0), 32'd4);
        check("t1_errs", 32'(err_cnt - e0), 32'd0);

        // 2: six reverse transitions wrap below zero
        for (int i = 0; i < 6; i++) begin drive(next_code(cur, 1'b0)); idle(7); end
        idle(8);
        check("t2_pos", 32'(bus.o_position), 32'd254);
        check("t2_dir", 32'(bus.o_dir), 32'd0);

        // 3: reset with pins at 11
        do_reset(2'b11);
        s0 = step_cnt;
        idle(12);
        check("t3_init_pos", 32'(bus.o_position), 32'd0);
        check("t3_init_steps", 32'(step_cnt - s0), 32'd0);
        drive(2'b10); idle(8);
        check("t3_pos", 32'(bus.o_position), 32'd1);

        // 4: two-cycle glitch on A
        s0 = step_cnt; e0 = err_cnt;
        drive(2'b00); idle(1); drive(2'b10); idle(10);
        check("t4_pos", 32'(bus.o_position), 32'd1);
        check("t4_steps", 32'(step_cnt - s0), 32'd0);
        check("t4_errs", 32'(err_cnt - e0), 32'd0);

        // 5: both channels toggle together
        drive(2'b00); idle(8);
        e0 = err_cnt;
        drive(2'b11); idle(10);
        check("t5_errs", 32'(err_cnt - e0), 32'd1);
        check("t5_pos", 32'(bus.o_position), 32'd2);
        drive(2'b10); idle(8);
        check("t5_after", 32'(bus.o_position), 32'd3);

        // 6: clear coincident with a step, then reset mid-sequence
        drive(2'b00); idle(5);
        bus.i_clear = 1'b1;
        @(negedge clock);
        bus.i_clear = 1'b0;
        check("t6_step", 32'(bus.o_step), 32'd1);
        check("t6_clear_pos", 32'(bus.o_position), 32'd0);
        idle(4);
        drive(2'b01); idle(8);
        check("t6_pos1", 32'(bus.o_position), 32'd1);
        drive(2'b11); idle(3);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_pos", 32'(bus.o_position), 32'd0);
        check("t6_rst_dir", 32'(bus.o_dir), 32'd0);
        check("t6_rst_step", 32'(bus.o_step), 32'd0);
        check("t6_rst_err", 32'(bus.o_error), 32'd0);
        reset = 1'b0;
        idle(12);

        // Randomized encoder activity, including out-of-rate and glitch cases.
        for (int it = 0; it < 700; it++) begin
            int act;
            act = int'($urandom_range(0, 99));
            if (act < 65) begin
                drive(next_code(cur, 1'($urandom_range(0, 1))));
                idle(int'($urandom_range(0, 9)));
            end else if (act < 78) begin
                logic [1:0] saved;
                saved = cur;
                drive(cur ^ ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b01));
                idle(int'($urandom_range(0, 2)));
                drive(saved);
                idle(int'($urandom_range(0, 6)));
            end else if (act < 84) begin
                drive(~cur);
                idle(int'($urandom_range(2, 8)));
            end else if (act < 94) begin
                @(negedge clock);
                bus.i_clear = 1'b1;
                if ($urandom_range(0, 1) != 0) begin
                    bus.i_a = ~bus.i_a;
                    cur[1] = bus.i_a;
                end
                @(negedge clock);
                bus.i_clear = 1'b0;
            end else if (act < 97) begin
                do_reset(2'($urandom_range(0, 3)));
                idle(int'($urandom_range(0, 12)));
            end else begin
                idle(int'($urandom_range(5, 20)));
            end
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
